pcs_rx_block_lock: RTL
======================

Name: pcs_rx_block_lock

Overview:
Receive-side 64B/66B block-lock controller for the PCS. It watches the 2-bit sync header and valid strobe from the gearbox and, in the manner of the 802.3 Clause 49 lock_fsm, decides when the gearbox has found the block boundary. It sequences the gearbox with a one-cycle slip request and gates the valid strobe into the descrambler/decoder until lock is achieved.

Parameters:
SH_CNT_MAX, 64, valid-strobed headers per test window
SH_INVALID_MAX, 16, invalid headers in one window that break an established lock
SLIP_WAIT, 4, valid beats discarded after a slip before testing resumes (gearbox settle time)
SLIP_CNT_WIDTH, 16, width of the saturating slip statistics counter

Ports:
clk  input  1  PCS clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
rx_pcs_header  input  2  sync header of the current 66-bit block
rx_pcs_valid  input  1  header/data valid this cycle
rx_slip  output  1  one-cycle pulse: gearbox shifts the block boundary by one bit
rx_block_lock  output  1  block lock established
rx_lock_valid  output  1  rx_pcs_valid AND rx_block_lock, combinational; feeds the descrambler/decoder valid
rx_slip_count  output  SLIP_CNT_WIDTH  total slips since reset, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=TEST, sh_cnt=0, sh_invalid_cnt=0, wait_cnt=0, rx_slip=0, rx_block_lock=0, rx_slip_count=0.
- Valid header: 2'b01 or 2'b10. Invalid header: 2'b00 or 2'b11.
- Only cycles with rx_pcs_valid=1 are evaluated. rx_pcs_valid=0 freezes all counters and the state.
- sh_cnt width is clog2(SH_CNT_MAX)+1. sh_invalid_cnt width is clog2(SH_INVALID_MAX)+1.
- State TEST, on each valid beat:
  - sh_cnt is incremented. An invalid header also increments sh_invalid_cnt.
  - Slip condition: the header is invalid AND (rx_block_lock=0 OR the new sh_invalid_cnt equals SH_INVALID_MAX).
    - Next cycle: rx_slip=1, rx_block_lock=0, counters cleared, rx_slip_count incremented (holds at all-ones).
    - Go to SLIP.
  - Otherwise, when the new sh_cnt equals SH_CNT_MAX:
    - If sh_invalid_cnt is 0 (including the current beat), rx_block_lock is set to 1. Otherwise rx_block_lock is left unchanged.
    - Both counters clear next cycle. Stay in TEST.
- Slip has priority over window completion when both fall on the same beat.
- Consequences of the rules above:
  - Before lock, any invalid header slips immediately.
  - After lock, up to SH_INVALID_MAX-1 invalid headers per window keep lock.
  - Once a window contains any invalid header, lock is held but cannot be re-qualified until a later all-valid window.
- State SLIP: lasts exactly one cycle with rx_slip=1, then goes to WAIT with wait_cnt=0. rx_slip is 0 in every other state.
- State WAIT: headers are ignored and wait_cnt counts valid beats. On the beat where wait_cnt reaches SLIP_WAIT, go to TEST with counters clear; that beat itself is not tested. SLIP_WAIT=0 goes directly SLIP->TEST.
- Latency: rx_block_lock and rx_slip change on the clock edge that samples the deciding header, i.e. they are visible one cycle after it.
- rx_lock_valid has zero latency with respect to rx_pcs_valid and is 0 whenever lock is absent.
- Reset asserted mid-window or mid-WAIT aborts immediately to reset values. There is no partial lock retention.

Test Plan:
- Reset release, 64 consecutive valid beats of header 01 -> rx_block_lock=1 on the cycle after beat 64, rx_slip never asserted, rx_slip_count=0.
- Before lock, beat 10 has header 11 -> rx_slip=1 for exactly one cycle after beat 10, rx_slip_count=1. The next 4 valid beats (even with header 00) are ignored. Then 64 good beats -> lock.
- Locked, one window with 15 invalid headers scattered in 64 -> lock held, no slip. The following window with 16 invalid headers -> rx_slip pulse and rx_block_lock=0 on the cycle after the 16th invalid header.
- Locked, rx_pcs_valid toggled 1/0 with a good header -> counters advance only on valid cycles. rx_lock_valid mirrors rx_pcs_valid exactly. Unlocked -> rx_lock_valid stays 0.
- rst driven low for a cycle at beat 40 of a locking window and at WAIT beat 2 -> all outputs 0 asynchronously. After release, a full 64-beat window is needed for lock.
- Force repeated slips beyond 65535 (SLIP_CNT_WIDTH reduced to 4 in a second run) -> rx_slip_count saturates at 15, no wrap.

Source files
------------

// File: rtl/pcs_rx_block_lock_if.sv
// Gearbox-to-lock-controller bundle: sync header and valid in, slip request,
// lock status and the lock-qualified valid out.
interface pcs_rx_block_lock_if #(
   parameter int SLIP_CNT_WIDTH = 16
);
   logic [1:0]                rx_pcs_header;
   logic                      rx_pcs_valid;
   logic                      rx_slip;
   logic                      rx_block_lock;
   logic                      rx_lock_valid;
   logic [SLIP_CNT_WIDTH-1:0] rx_slip_count;

   modport master (
      output rx_pcs_header,
      output rx_pcs_valid,
      input  rx_slip,
      input  rx_block_lock,
      input  rx_lock_valid,
      input  rx_slip_count
   );

   modport slave (
      input  rx_pcs_header,
      input  rx_pcs_valid,
      output rx_slip,
      output rx_block_lock,
      output rx_lock_valid,
      output rx_slip_count
   );
endinterface

// File: rtl/pcs_rx_block_lock.sv
// 64B/66B receive block-lock controller: tests sync headers in fixed windows,
// requests gearbox slips on bad alignment and qualifies valid once locked.
module pcs_rx_block_lock #(
   parameter int SH_CNT_MAX     = 64,
   parameter int SH_INVALID_MAX = 16,
   parameter int SLIP_WAIT      = 4,
   parameter int SLIP_CNT_WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   pcs_rx_block_lock_if.slave bus
);
   localparam int SH_W   = $clog2(SH_CNT_MAX) + 1;
   localparam int INV_W  = $clog2(SH_INVALID_MAX) + 1;
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1) + 1;

   localparam logic [SH_W-1:0]   SH_CNT_MAX_C     = SH_W'(SH_CNT_MAX);
   localparam logic [INV_W-1:0]  SH_INVALID_MAX_C = INV_W'(SH_INVALID_MAX);
   localparam logic [WAIT_W-1:0] SLIP_WAIT_C      = WAIT_W'(SLIP_WAIT);

   typedef enum logic [1:0] {
      ST_TEST = 2'd0,
      ST_SLIP = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                    state_reg, state_next;
   logic [SH_W-1:0]           sh_cnt_reg, sh_cnt_next;
   logic [INV_W-1:0]          sh_invalid_cnt_reg, sh_invalid_cnt_next;
   logic [WAIT_W-1:0]         wait_cnt_reg, wait_cnt_next;
   logic                      slip_reg, slip_next;
   logic                      lock_reg, lock_next;
   logic [SLIP_CNT_WIDTH-1:0] slip_count_reg, slip_count_next;

   logic                      hdr_invalid;
   logic [SH_W-1:0]           sh_cnt_inc;
   logic [INV_W-1:0]          sh_invalid_inc;

   // Only 01 and 10 are legal sync headers
   assign hdr_invalid    = (bus.rx_pcs_header == 2'b00) || (bus.rx_pcs_header == 2'b11);
   assign sh_cnt_inc     = sh_cnt_reg + 1'b1;
   assign sh_invalid_inc = sh_invalid_cnt_reg + INV_W'(hdr_invalid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg          <= ST_TEST;
         sh_cnt_reg         <= '0;
         sh_invalid_cnt_reg <= '0;
         wait_cnt_reg       <= '0;
         slip_reg           <= 1'b0;
         lock_reg           <= 1'b0;
         slip_count_reg     <= '0;
      end else begin
         state_reg          <= state_next;
         sh_cnt_reg         <= sh_cnt_next;
         sh_invalid_cnt_reg <= sh_invalid_cnt_next;
         wait_cnt_reg       <= wait_cnt_next;
         slip_reg           <= slip_next;
         lock_reg           <= lock_next;
         slip_count_reg     <= slip_count_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      sh_cnt_next         = sh_cnt_reg;
      sh_invalid_cnt_next = sh_invalid_cnt_reg;
      wait_cnt_next       = wait_cnt_reg;
      slip_next           = 1'b0;
      lock_next           = lock_reg;
      slip_count_next     = slip_count_reg;

      case (state_reg)
         ST_TEST: begin
            if (bus.rx_pcs_valid) begin
               // Slip outranks window completion on the same beat
               if (hdr_invalid && (!lock_reg || (sh_invalid_inc == SH_INVALID_MAX_C))) begin
                  slip_next           = 1'b1;
                  lock_next           = 1'b0;
                  sh_cnt_next         = '0;
                  sh_invalid_cnt_next = '0;
                  if (slip_count_reg != '1) begin
                     slip_count_next = slip_count_reg + 1'b1;
                  end
                  state_next = ST_SLIP;
               end else if (sh_cnt_inc == SH_CNT_MAX_C) begin
                  if (sh_invalid_inc == '0) begin
                     lock_next = 1'b1;
                  end
                  sh_cnt_next         = '0;
                  sh_invalid_cnt_next = '0;
               end else begin
                  sh_cnt_next         = sh_cnt_inc;
                  sh_invalid_cnt_next = sh_invalid_inc;
               end
            end
         end
         ST_SLIP: begin
            wait_cnt_next = '0;
            state_next    = (SLIP_WAIT == 0) ? ST_TEST : ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.rx_pcs_valid) begin
               if ((wait_cnt_reg + 1'b1) == SLIP_WAIT_C) begin
                  wait_cnt_next = '0;
                  state_next    = ST_TEST;
               end else begin
                  wait_cnt_next = wait_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_TEST;
         end
      endcase
   end

   assign bus.rx_slip       = slip_reg;
   assign bus.rx_block_lock = lock_reg;
   assign bus.rx_lock_valid = bus.rx_pcs_valid & lock_reg;
   assign bus.rx_slip_count = slip_count_reg;
endmodule
